vault_work_dispatcher: RTL and testbench
========================================

Name: vault_work_dispatcher

Overview:
- Upstream feeder for the vault mining core.
- Accepts block-header jobs from the host over a valid/ready interface and buffers one pending job.
- Drives the 640-bit work_package into the mining core and watches its golden_nonce output.
- Returns a per-job result (found nonce or timeout) over a second valid/ready interface.

Parameters:
HDR_W, 640, job header / work_package width
ID_W, 8, job identifier width
SETTLE_CYCLES, 4, cycles golden_nonce is ignored after a new work_package is driven (minimum 1)
TIMEOUT_CYCLES, 1000000, MINE cycles before a job is abandoned (minimum 1)

Ports:
clk  in  1  single clock
rst_n  in  1  reset, asynchronous, active-low
job_valid  in  1  host job offered
job_ready  out  1  dispatcher can accept a job
job_header  in  HDR_W  block header
job_id  in  ID_W  host tag
abort  in  1  cancel active job
work_package  out  HDR_W  header to mining core, registered
golden_nonce  in  32  from mining core; nonzero = found
res_valid  out  1  result available
res_ready  in  1  host accepts result
res_nonce  out  32  found nonce, 0 on timeout
res_job_id  out  ID_W  tag of reported job
res_found  out  1  1 = nonce found, 0 = timeout
busy  out  1  state != IDLE
jobs_done  out  16  completed results, wraps

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; pending buffer empty.
  - work_package, res_*, jobs_done and all counters = 0.
  - A job in flight or pending at reset is discarded with no result.
- Pending buffer:
  - One entry holds header and id.
  - job_ready = !pend_full (combinational).
  - Accept when job_valid && job_ready.
  - No same-cycle pop and push: a pop frees the slot starting the next cycle.
- IDLE:
  - If pend_full: work_package <= pend header; active_id <= pend id; pend_full <= 0; settle counter <= SETTLE_CYCLES-1; go to SETTLE.
  - work_package otherwise holds its last value.
- SETTLE:
  - golden_nonce is ignored.
  - Counter decrements each cycle; at 0, go to MINE with the timer cleared.
- MINE:
  - Timer increments each cycle.
  - If golden_nonce != 0: res_nonce <= golden_nonce; res_found <= 1; go to REPORT.
  - Else, if timer == TIMEOUT_CYCLES-1: res_nonce <= 0; res_found <= 0; go to REPORT.
  - Found takes priority over timeout in the same cycle.
  - Earliest found result: the first MINE cycle, i.e. SETTLE_CYCLES+1 cycles after leaving IDLE.
- REPORT:
  - res_valid = 1; res_job_id = active_id; res_* stay stable until the handshake.
  - On res_valid && res_ready: jobs_done += 1 (mod 2^16); res_valid <= 0; go to IDLE.
  - The next job can therefore load no earlier than the following cycle.
- abort:
  - In SETTLE or MINE: go to IDLE, no result, jobs_done unchanged, pending entry kept.
  - Ignored in IDLE and REPORT.
  - abort together with found or timeout in the same cycle: abort wins.
- job_valid in any state only fills the pending buffer; it never preempts the active job.
- Timer is 32-bit; TIMEOUT_CYCLES must be below 2^32.

Test Plan:
1. Reset, then one job (header=640'h1..., id=8'h05); golden_nonce=32'hDEADBEEF from the 3rd MINE cycle → single res_valid with res_nonce=DEADBEEF, res_found=1, res_job_id=05, jobs_done=1.
2. golden_nonce held at 32'h12345678 (stale) during SETTLE, dropping to 0 before MINE; TIMEOUT_CYCLES=16 → no early report; result has res_found=0, res_nonce=0 exactly 16 MINE cycles after entry.
3. Back-to-back jobs A and B with res_ready=0 for 10 cycles after A's result → job_ready=0 while B is pending; A's result stays stable; after the handshake, B loads and work_package = B's header.
4. abort in the 2nd MINE cycle with job C pending → no result for the active job; C loads next; jobs_done unchanged.
5. Found and timeout in the same cycle (nonce on the last timer cycle) → res_found=1 with that nonce; abort asserted in the same cycle instead → no result.
6. rst_n low mid-MINE with a pending job → all outputs 0 immediately (asynchronous); after release, no result appears and job_ready=1.

Source files
------------

// File: rtl/vault_work_dispatcher.sv
// vault_work_dispatcher: host job intake, one-entry pending buffer, work_package
// driver for the mining core, and per-job result return (found nonce or timeout).
module vault_work_dispatcher #(
    parameter int HDR_W          = 640,
    parameter int ID_W           = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [HDR_W-1:0] job_header,
    input  logic [ID_W-1:0]  job_id,
    input  logic             abort,
    output logic [HDR_W-1:0] work_package,
    input  logic [31:0]      golden_nonce,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_nonce,
    output logic [ID_W-1:0]  res_job_id,
    output logic             res_found,
    output logic             busy,
    output logic [15:0]      jobs_done
);

    typedef enum logic [1:0] {IDLE, SETTLE, MINE, REPORT} state_t;

    state_t            r_state, w_next;
    logic              r_pend_full;
    logic [HDR_W-1:0]  r_pend_hdr;
    logic [ID_W-1:0]   r_pend_id;
    logic [ID_W-1:0]   r_active_id;
    logic [HDR_W-1:0]  r_work_package;
    logic [31:0]       r_settle_cnt;
    logic [31:0]       r_timer;
    logic              r_res_valid;
    logic [31:0]       r_res_nonce;
    logic              r_res_found;
    logic [15:0]       r_jobs_done;

    logic w_push, w_load, w_found, w_timeout, w_done;

    // Handshake and event decode; abort outranks found/timeout via the FSM order.
    assign w_push    = job_valid && !r_pend_full;
    assign w_load    = (r_state == IDLE) && r_pend_full;
    assign w_found   = (r_state == MINE) && !abort && (golden_nonce != 32'd0);
    assign w_timeout = (r_state == MINE) && !abort && (golden_nonce == 32'd0) &&
                       (r_timer == 32'(TIMEOUT_CYCLES - 1));
    assign w_done    = (r_state == REPORT) && res_ready;

    assign job_ready    = !r_pend_full;
    assign work_package = r_work_package;
    assign res_valid    = r_res_valid;
    assign res_nonce    = r_res_nonce;
    assign res_found    = r_res_found;
    assign res_job_id   = r_active_id;
    assign busy         = (r_state != IDLE);
    assign jobs_done    = r_jobs_done;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (r_pend_full) w_next = SETTLE;
            SETTLE:  if (abort) w_next = IDLE;
                     else if (r_settle_cnt == 32'd0) w_next = MINE;
            MINE:    if (abort) w_next = IDLE;
                     else if (w_found || w_timeout) w_next = REPORT;
            REPORT:  if (res_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Pending slot: push only when empty, pop only when full, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_full <= 1'b0;
            r_pend_hdr  <= '0;
            r_pend_id   <= '0;
        end else if (w_push) begin
            r_pend_full <= 1'b1;
            r_pend_hdr  <= job_header;
            r_pend_id   <= job_id;
        end else if (w_load) begin
            r_pend_full <= 1'b0;
        end
    end

    // Load the active job into the mining core; header holds until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work_package <= '0;
            r_active_id    <= '0;
        end else if (w_load) begin
            r_work_package <= r_pend_hdr;
            r_active_id    <= r_pend_id;
        end
    end

    // Settle countdown masks stale nonces; mine timer counts MINE cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt <= '0;
            r_timer      <= '0;
        end else begin
            if (w_load)
                r_settle_cnt <= 32'(SETTLE_CYCLES - 1);
            else if (r_state == SETTLE && r_settle_cnt != 32'd0)
                r_settle_cnt <= r_settle_cnt - 32'd1;
            if (r_state == SETTLE)
                r_timer <= '0;
            else if (r_state == MINE)
                r_timer <= r_timer + 32'd1;
        end
    end

    // Result capture and completion count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_nonce <= '0;
            r_res_found <= 1'b0;
            r_jobs_done <= '0;
        end else if (w_found || w_timeout) begin
            r_res_valid <= 1'b1;
            r_res_nonce <= w_found ? golden_nonce : 32'd0;
            r_res_found <= w_found;
        end else if (w_done) begin
            r_res_valid <= 1'b0;
            r_jobs_done <= r_jobs_done + 16'd1;
        end
    end

endmodule

// File: tb/tb_vault_work_dispatcher.sv
// Scoreboard bench for vault_work_dispatcher (SETTLE_CYCLES=4, TIMEOUT_CYCLES=16).
module tb_vault_work_dispatcher;

    localparam int HDR_W = 640;
    localparam int ID_W  = 8;
    localparam int SC    = 4;
    localparam int TO    = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             job_valid = 1'b0;
    logic             job_ready;
    logic [HDR_W-1:0] job_header = '0;
    logic [ID_W-1:0]  job_id = '0;
    logic             abort = 1'b0;
    logic [HDR_W-1:0] work_package;
    logic [31:0]      golden_nonce = '0;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [31:0]      res_nonce;
    logic [ID_W-1:0]  res_job_id;
    logic             res_found;
    logic             busy;
    logic [15:0]      jobs_done;

    typedef struct {
        logic [31:0]     nonce;
        logic [ID_W-1:0] id;
        logic            found;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    vault_work_dispatcher #(.HDR_W(HDR_W), .ID_W(ID_W), .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
        .job_header(job_header), .job_id(job_id), .abort(abort),
        .work_package(work_package), .golden_nonce(golden_nonce),
        .res_valid(res_valid), .res_ready(res_ready), .res_nonce(res_nonce),
        .res_job_id(res_job_id), .res_found(res_found), .busy(busy), .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;

    // Scoreboard: every completed handshake must match the next expected result.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got nonce=%h id=%h found=%b, none expected",
                         res_nonce, res_job_id, res_found);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (res_nonce !== e.nonce || res_job_id !== e.id || res_found !== e.found) begin
                    failures++;
                    $display("FAIL sb_result: got nonce=%h id=%h found=%b, want nonce=%h id=%h found=%b",
                             res_nonce, res_job_id, res_found, e.nonce, e.id, e.found);
                end
            end
        end
    end

    function automatic logic [HDR_W-1:0] hdr(input logic [31:0] w);
        return {20{w}};
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the job was accepted.
    task automatic submit(input logic [HDR_W-1:0] h, input logic [ID_W-1:0] id);
        int n = 0;
        while (!job_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!job_ready) begin
            checks++; failures++;
            $display("FAIL submit_timeout: job_ready=%b want 1", job_ready);
        end
        job_header = h; job_id = id; job_valid = 1'b1;
        @(posedge clk); #1;
        job_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_result(input int max);
        int n = 0;
        while (!res_valid && n < max) begin @(posedge clk); #1; n++; end
        checks++;
        if (!res_valid) begin
            failures++;
            $display("FAIL wait_result: res_valid=%b after %0d cycles want 1", res_valid, max);
        end
    endtask

    task automatic chk_done(input string nm, input logic [15:0] want);
        checks++;
        if (jobs_done !== want) begin
            failures++;
            $display("FAIL %s: jobs_done=%0d want %0d", nm, jobs_done, want);
        end
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (work_package !== '0 || res_valid !== 1'b0 || res_nonce !== 32'd0 || res_job_id !== '0 ||
            res_found !== 1'b0 || busy !== 1'b0 || jobs_done !== 16'd0 || job_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: rv=%b rn=%h rid=%h rf=%b busy=%b done=%0d ready=%b",
                     res_valid, res_nonce, res_job_id, res_found, busy, jobs_done, job_ready);
        end
        #19 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_found;
        int early = 0;
        submit(hdr(32'h11111111), 8'h05);
        step(5);                         // first MINE cycle
        checks++;
        if (work_package !== hdr(32'h11111111) || busy !== 1'b1) begin
            failures++;
            $display("FAIL found_load: busy=%b wp[31:0]=%h want 11111111", busy, work_package[31:0]);
        end
        for (int i = 0; i < 2; i++) begin if (res_valid) early++; step(1); end
        q.push_back('{32'hDEADBEEF, 8'h05, 1'b1});
        golden_nonce = 32'hDEADBEEF;     // third MINE cycle
        step(1);
        checks++;
        if (res_valid !== 1'b1 || early != 0) begin
            failures++;
            $display("FAIL found_timing: res_valid=%b early=%0d want 1/0", res_valid, early);
        end
        golden_nonce = 32'd0;
        step(1);
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL found_single: res_valid=%b want 0", res_valid);
        end
        chk_done("found_done", 16'd1);
    endtask

    task automatic test_timeout_stale;
        int early = 0;
        q.push_back('{32'd0, 8'h22, 1'b0});
        submit(hdr(32'h22222222), 8'h22);
        golden_nonce = 32'h12345678;
        for (int i = 0; i < 4; i++) begin step(1); if (res_valid) early++; end
        golden_nonce = 32'd0;            // last SETTLE cycle
        step(1);
        for (int i = 0; i < TO; i++) begin if (res_valid) early++; step(1); end
        checks++;
        if (res_valid !== 1'b1 || early != 0) begin
            failures++;
            $display("FAIL timeout_timing: res_valid=%b early=%0d want 1/0", res_valid, early);
        end
        step(1);
        chk_done("timeout_done", 16'd2);
    endtask

    task automatic test_back_to_back;
        int bad = 0;
        res_ready = 1'b0;
        submit(hdr(32'hAAAA0001), 8'hA1);
        submit(hdr(32'hBBBB0002), 8'hB2);
        golden_nonce = 32'h0A0A0A0A;
        wait_result(50);
        golden_nonce = 32'd0;
        for (int i = 0; i < 10; i++) begin
            if (res_valid !== 1'b1 || res_nonce !== 32'h0A0A0A0A || res_job_id !== 8'hA1 ||
                res_found !== 1'b1 || job_ready !== 1'b0) bad++;
            step(1);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL b2b_hold: %0d unstable cycles want 0", bad);
        end
        q.push_back('{32'h0A0A0A0A, 8'hA1, 1'b1});
        q.push_back('{32'd0, 8'hB2, 1'b0});
        res_ready = 1'b1;
        step(2);
        checks++;
        if (work_package !== hdr(32'hBBBB0002) || busy !== 1'b1 || jobs_done !== 16'd3) begin
            failures++;
            $display("FAIL b2b_load: wp[31:0]=%h busy=%b done=%0d want bbbb0002/1/3",
                     work_package[31:0], busy, jobs_done);
        end
        wait_result(60);
        step(1);
        chk_done("b2b_done", 16'd4);
    endtask

    task automatic test_abort;
        submit(hdr(32'hDDDD0004), 8'hD4);
        submit(hdr(32'hCCCC0003), 8'hC3);
        step(4);                         // second MINE cycle of D
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: busy=%b res_valid=%b want 0/0", busy, res_valid);
        end
        step(1);
        checks++;
        if (work_package !== hdr(32'hCCCC0003) || busy !== 1'b1 || job_ready !== 1'b1 || jobs_done !== 16'd4) begin
            failures++;
            $display("FAIL abort_next: wp[31:0]=%h busy=%b ready=%b done=%0d want cccc0003/1/1/4",
                     work_package[31:0], busy, job_ready, jobs_done);
        end
        q.push_back('{32'd0, 8'hC3, 1'b0});
        wait_result(60);
        step(1);
        chk_done("abort_done", 16'd5);
    endtask

    task automatic test_same_cycle;
        submit(hdr(32'hEEEE0005), 8'hE5);
        step(5 + TO - 1);                // last timer cycle
        q.push_back('{32'hCAFEF00D, 8'hE5, 1'b1});
        golden_nonce = 32'hCAFEF00D;
        step(1);
        golden_nonce = 32'd0;
        checks++;
        if (res_valid !== 1'b1) begin
            failures++;
            $display("FAIL same_found: res_valid=%b want 1", res_valid);
        end
        step(1);
        chk_done("same_found_done", 16'd6);
        submit(hdr(32'hEEEE0006), 8'hE6);
        step(5 + TO - 1);
        golden_nonce = 32'h77777777;
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        golden_nonce = 32'd0;
        step(3);
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || jobs_done !== 16'd6) begin
            failures++;
            $display("FAIL same_abort: rv=%b busy=%b done=%0d want 0/0/6", res_valid, busy, jobs_done);
        end
    endtask

    task automatic test_async_reset;
        int bad = 0;
        submit(hdr(32'hF0F0F0F0), 8'hF1);
        submit(hdr(32'hF2F2F2F2), 8'hF2);
        step(3);                         // first MINE cycle, F2 pending
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (work_package !== '0 || res_valid !== 1'b0 || res_nonce !== 32'd0 || res_job_id !== '0 ||
            res_found !== 1'b0 || busy !== 1'b0 || jobs_done !== 16'd0) begin
            failures++;
            $display("FAIL async_reset: wp0=%h rv=%b busy=%b done=%0d want all 0",
                     work_package[31:0], res_valid, busy, jobs_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        for (int i = 0; i < 30; i++) begin if (res_valid || busy) bad++; step(1); end
        checks++;
        if (bad != 0 || job_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: activity=%0d ready=%b want 0/1", bad, job_ready);
        end
    endtask

    initial begin
        test_reset();
        test_found();
        test_timeout_stale();
        test_back_to_back();
        test_abort();
        test_same_cycle();
        test_async_reset();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d results outstanding want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
